// File: rtl/cpu_pkg.sv
// cpu_pkg: shared fetch-stage types, instruction-format constants and decode helper.
// The HALT state exists only when FETCH_HALT_EN is defined.
package cpu_pkg;

  localparam int unsigned XLEN = 16;
  localparam int unsigned BLEN = 8;

  localparam logic [XLEN-1:0] ONE_ARG_MASK  = 16'hC000;
  localparam logic [XLEN-1:0] ONE_ARG_VAL   = 16'h8000;
  localparam logic [XLEN-1:0] SRC_MASK      = 16'h0600;
  localparam logic [XLEN-1:0] SRC_DATA      = 16'h0200;

  localparam logic [XLEN-1:0] INST_LEN_BASE = 16'd2;
  localparam logic [XLEN-1:0] INST_LEN_DATA = 16'd3;

  typedef enum logic [2:0] {
    FETCH_HI   = 3'd0,
    FETCH_LO   = 3'd1,
    FETCH_DATA = 3'd2,
`ifdef FETCH_HALT_EN
    HALT       = 3'd4,
`endif
    ISSUE      = 3'd3
  } fetch_state_e;

  // One-argument instruction whose source is an inline data byte.
  function automatic logic has_data(input logic [XLEN-1:0] inst);
    return ((inst & ONE_ARG_MASK) == ONE_ARG_VAL) && ((inst & SRC_MASK) == SRC_DATA);
  endfunction

endpackage

// File: rtl/fetch_pc.sv
// fetch_pc: fetch program counter register with its reset / advance / branch mux.
module fetch_pc
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 16'h0000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            adv_i,
  input  logic [XLEN-1:0] len_i,
  input  logic            branch_i,
  input  logic [XLEN-1:0] base_i,
  input  logic [XLEN-1:0] offset_i,
  output logic [XLEN-1:0] fetch_pc_o,
  output logic [XLEN-1:0] next_pc_c_o,
  output logic [XLEN-1:0] plus1_c_o,
  output logic [XLEN-1:0] plus2_c_o
);

  logic [XLEN-1:0] fetch_pc_q;
  logic [XLEN-1:0] fetch_pc_d;

  // Next fetch address: branch target wins over sequential advance.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (branch_i) begin
      fetch_pc_d = base_i + offset_i;
    end else if (adv_i) begin
      fetch_pc_d = fetch_pc_q + len_i;
    end
  end

  // Fetch PC register with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
    end else begin
      fetch_pc_q <= fetch_pc_d;
    end
  end

  assign fetch_pc_o  = fetch_pc_q;
  assign next_pc_c_o = fetch_pc_d;
  assign plus1_c_o   = fetch_pc_q + 16'd1;
  assign plus2_c_o   = fetch_pc_q + 16'd2;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: byte-wide instruction fetch sequencer feeding the decoder.
// Define FETCH_HALT_EN to add the halt input and the HALT state.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 16'h0000
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            mem_req,
  output logic [XLEN-1:0] mem_addr,
  input  logic            mem_ack,
  input  logic [BLEN-1:0] mem_rdata,
  output logic [XLEN-1:0] inst,
  output logic [BLEN-1:0] data,
  output logic            dec_en,
  input  logic            exec_ready,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_offset,
  input  logic            skip_next,
`ifdef FETCH_HALT_EN
  input  logic            halt,
`endif
  output logic [XLEN-1:0] pc
);

  fetch_state_e    state_q;
  logic            req_q;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] inst_q;
  logic [BLEN-1:0] data_q;
  logic            dec_en_q;
  logic [XLEN-1:0] pc_q;
  logic            skip_q;

  logic [XLEN-1:0] fetch_pc_cur;
  logic [XLEN-1:0] next_pc_c;
  logic [XLEN-1:0] plus1_c;
  logic [XLEN-1:0] plus2_c;
  logic [XLEN-1:0] len_c;
  logic            adv_c;
  logic            branch_c;
  logic            lo_has_data_c;

  // PC advance / redirect strobes for the fetch_pc sub-block.
  always_comb begin
    lo_has_data_c = has_data({inst_q[15:8], mem_rdata});
    adv_c         = 1'b0;
    len_c         = INST_LEN_BASE;
    branch_c      = 1'b0;
    case (state_q)
      FETCH_LO:   adv_c = req_q && mem_ack && !lo_has_data_c;
      FETCH_DATA: begin
        adv_c = req_q && mem_ack;
        len_c = INST_LEN_DATA;
      end
      ISSUE:      branch_c = !skip_q && exec_ready && branch_taken;
      default:    ;
    endcase
  end

  fetch_pc #(.RESET_PC(RESET_PC)) u_fetch_pc (
    .clk        (clk),
    .rst_n      (rst_n),
    .adv_i      (adv_c),
    .len_i      (len_c),
    .branch_i   (branch_c),
    .base_i     (pc_q),
    .offset_i   (branch_offset),
    .fetch_pc_o (fetch_pc_cur),
    .next_pc_c_o(next_pc_c),
    .plus1_c_o  (plus1_c),
    .plus2_c_o  (plus2_c)
  );

  // Fetch sequencer: each byte state spends its entry cycle with mem_req low.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= FETCH_HI;
      req_q    <= 1'b0;
      addr_q   <= RESET_PC;
      inst_q   <= '0;
      data_q   <= '0;
      dec_en_q <= 1'b0;
      pc_q     <= RESET_PC;
      skip_q   <= 1'b0;
    end else begin
      case (state_q)
        FETCH_HI: begin
          if (!req_q) begin
`ifdef FETCH_HALT_EN
            if (halt) state_q <= HALT;
            else      req_q   <= 1'b1;
`else
            req_q <= 1'b1;
`endif
          end else if (mem_ack) begin
            inst_q[15:8] <= mem_rdata;
            req_q        <= 1'b0;
            addr_q       <= plus1_c;
            state_q      <= FETCH_LO;
          end
        end
        FETCH_LO: begin
          if (!req_q) begin
            req_q <= 1'b1;
          end else if (mem_ack) begin
            inst_q[7:0] <= mem_rdata;
            req_q       <= 1'b0;
            if (lo_has_data_c) begin
              addr_q  <= plus2_c;
              state_q <= FETCH_DATA;
            end else begin
              data_q   <= '0;
              pc_q     <= fetch_pc_cur;
              dec_en_q <= !skip_q;
              state_q  <= ISSUE;
            end
          end
        end
        FETCH_DATA: begin
          if (!req_q) begin
            req_q <= 1'b1;
          end else if (mem_ack) begin
            data_q   <= mem_rdata;
            req_q    <= 1'b0;
            pc_q     <= fetch_pc_cur;
            dec_en_q <= !skip_q;
            state_q  <= ISSUE;
          end
        end
        ISSUE: begin
          if (skip_q) begin
            skip_q  <= 1'b0;
            addr_q  <= next_pc_c;
            state_q <= FETCH_HI;
          end else if (exec_ready) begin
            dec_en_q <= 1'b0;
            skip_q   <= skip_next && !branch_taken;
            addr_q   <= next_pc_c;
`ifdef FETCH_HALT_EN
            state_q  <= halt ? HALT : FETCH_HI;
`else
            state_q  <= FETCH_HI;
`endif
          end
        end
`ifdef FETCH_HALT_EN
        HALT: begin
          if (!halt) state_q <= FETCH_HI;
        end
`endif
        default: state_q <= FETCH_HI;
      endcase
    end
  end

  assign mem_req  = req_q;
  assign mem_addr = addr_q;
  assign inst     = inst_q;
  assign data     = data_q;
  assign dec_en   = dec_en_q;
  assign pc       = pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized fetch traffic checked against a queue-based program model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [7:0]  mem_rdata = 8'h00;
  logic [15:0] inst;
  logic [7:0]  data;
  logic        dec_en;
  logic        exec_ready = 1'b0;
  logic        branch_taken = 1'b0;
  logic [15:0] branch_offset = 16'h0000;
  logic        skip_next = 1'b0;
  logic [15:0] pc;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(16'h0000)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata),
    .inst         (inst),
    .data         (data),
    .dec_en       (dec_en),
    .exec_ready   (exec_ready),
    .branch_taken (branch_taken),
    .branch_offset(branch_offset),
    .skip_next    (skip_next),
`ifdef FETCH_HALT_EN
    .halt         (1'b0),
`endif
    .pc           (pc)
  );

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] inst;
    logic [7:0]  data;
  } issue_t;

  logic [7:0]  mem [0:65535];
  logic [15:0] exp_addr_q [$];
  issue_t      exp_issue_q [$];
  logic [15:0] m_cur;
  logic [15:0] m_next;

  int n_checks = 0;
  int n_fail   = 0;
  int issues   = 0;
  int wait_min = 0;
  int wait_max = 0;
  int wcnt     = 0;
  int wtarget  = 0;
  bit stray    = 1'b0;
  int cyc      = 0;
  int last_rst = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: read an instruction starting at a, queueing the byte addresses it needs.
  task automatic model_fetch(input logic [15:0] a, output issue_t e, output logic [15:0] nxt);
    logic [7:0]  hi;
    logic [15:0] a1;
    logic [15:0] a2;
    bit          has;
    a1  = a + 16'd1;
    a2  = a + 16'd2;
    hi  = mem[a];
    has = (hi[7:6] == 2'b10) && (hi[2:1] == 2'b01);
    exp_addr_q.push_back(a);
    exp_addr_q.push_back(a1);
    e.pc   = a;
    e.inst = {hi, mem[a1]};
    e.data = 8'h00;
    nxt    = a2;
    if (has) begin
      exp_addr_q.push_back(a2);
      e.data = mem[a2];
      nxt    = a + 16'd3;
    end
  endtask

  task automatic model_issue_from(input logic [15:0] a);
    issue_t      e;
    logic [15:0] nxt;
    model_fetch(a, e, nxt);
    exp_issue_q.push_back(e);
    m_cur  = a;
    m_next = nxt;
  endtask

  task automatic model_accept(input bit br, input logic [15:0] off, input bit sk);
    issue_t      e;
    logic [15:0] tgt;
    logic [15:0] nxt;
    tgt = br ? m_cur + off : m_next;
    if (sk && !br) begin
      model_fetch(tgt, e, nxt);
      tgt = nxt;
    end
    model_issue_from(tgt);
  endtask

  task automatic model_reset();
    exp_addr_q.delete();
    exp_issue_q.delete();
    model_issue_from(16'h0000);
  endtask

  // Memory responder: random wait states, address check on every completed read.
  logic [15:0] held_addr;
  always @(negedge clk) begin
    mem_ack = 1'b0;
    if (rst_n && mem_req) begin
      if (wcnt == 0) begin
        wtarget   = $urandom_range(wait_max, wait_min);
        held_addr = mem_addr;
      end else begin
        check("addr_stable", 32'(mem_addr), 32'(held_addr));
      end
      if (wcnt >= wtarget) begin
        mem_ack   = 1'b1;
        mem_rdata = mem[mem_addr];
        wcnt      = 0;
        if (exp_addr_q.size() == 0) check("unexpected_read", 32'(mem_addr), 32'hFFFF_FFFF);
        else check("mem_addr", 32'(mem_addr), 32'(exp_addr_q.pop_front()));
      end else begin
        wcnt++;
        mem_rdata = 8'($urandom);
      end
    end else begin
      wcnt = 0;
      if (stray) begin
        mem_ack   = 1'b1;
        mem_rdata = 8'($urandom);
      end
    end
  end

  // Execute-stage stimulus: random accept / branch / skip, fed to the model on acceptance.
  always @(negedge clk) begin
    int sel;
    exec_ready   = ($urandom_range(1, 0) == 1);
    branch_taken = ($urandom_range(3, 0) == 0);
    skip_next    = ($urandom_range(3, 0) == 0);
    sel          = int'($urandom_range(7, 0));
    if (sel == 0)      branch_offset = 16'hFFFF - m_cur;
    else if (sel == 1) branch_offset = 16'hFFFE - m_cur;
    else if (sel < 5)  branch_offset = 16'($urandom_range(64, 0)) - 16'd32;
    else               branch_offset = 16'($urandom);
    if (rst_n && dec_en && exec_ready) model_accept(branch_taken, branch_offset, skip_next);
  end

  // Issue monitor: compare each new issue against the scoreboard and check hold stability.
  issue_t cur;
  bit     prev_dec = 1'b0;
  bit     first_after_rst = 1'b0;
  always @(posedge clk) begin
    cyc++;
    #1;
    if (!rst_n) begin
      prev_dec        = 1'b0;
      last_rst        = cyc;
      first_after_rst = 1'b1;
    end else begin
      if (dec_en && !prev_dec) begin
        issues++;
        if (exp_issue_q.size() == 0) begin
          check("unexpected_issue", 32'(pc), 32'hFFFF_FFFF);
        end else begin
          cur = exp_issue_q.pop_front();
          check("inst", 32'(inst), 32'(cur.inst));
          check("data", 32'(data), 32'(cur.data));
          check("pc", 32'(pc), 32'(cur.pc));
          if (first_after_rst && wait_max == 0) check("first_latency", 32'(cyc - last_rst), 32'd4);
        end
        first_after_rst = 1'b0;
      end else if (dec_en) begin
        check("hold_inst", 32'(inst), 32'(cur.inst));
        check("hold_pc", 32'(pc), 32'(cur.pc));
        check("hold_data", 32'(data), 32'(cur.data));
      end
      prev_dec = dec_en;
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mem_req"}, 32'(mem_req), 32'd0);
    check({tag, "_mem_addr"}, 32'(mem_addr), 32'h0000);
    check({tag, "_inst"}, 32'(inst), 32'h0000);
    check({tag, "_data"}, 32'(data), 32'h00);
    check({tag, "_dec_en"}, 32'(dec_en), 32'd0);
    check({tag, "_pc"}, 32'(pc), 32'h0000);
  endtask

  task automatic run_issues(input int n);
    int target;
    target = issues + n;
    for (int c = 0; c < 20000 && issues < target; c++) @(negedge clk);
    check("progress", 32'(issues >= target), 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h80; mem[1] = 8'h05;
    mem[2] = 8'h8A; mem[3] = 8'h00; mem[4] = 8'h2C;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    run_issues(150);
    wait_max = 4;
    run_issues(150);

    // Reset while a read is stalled; a stray ack right after reset must be ignored.
    wait_min = 8;
    wait_max = 8;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk);
      #2;
      if (mem_req && wcnt >= 3) break;
    end
    check("stall_seen", 32'(mem_req), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #2;
    check_reset_outputs("midrst");
    wait_min = 0;
    wait_max = 0;
    model_reset();
    stray = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #2;
    stray = 1'b0;

    run_issues(100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch sequencer directly upstream of the instruction decoder.
- Owns the program counter and reads instruction bytes over an 8-bit request/acknowledge memory port. Assembles each 16-bit instruction and, when the instruction's source field requires it, fetches one trailing operand byte.
- Presents inst/data with a one-cycle-wide issue strobe (dec_en) and waits for the execute stage to accept before fetching again.
- Applies branch and skip redirects reported by execute.

Parameters:
- RESET_PC, 16'h0000: PC value loaded at reset.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- mem_req  out  1  byte read request; held until mem_ack
- mem_addr  out  16  byte address of the current request
- mem_ack  in  1  read complete; mem_rdata valid this cycle
- mem_rdata  in  8  read byte
- inst  out  16  assembled instruction, to decoder inst
- data  out  8  operand byte, to decoder data; 8'h00 when no operand was fetched
- dec_en  out  1  issue strobe, to decoder en; high only in ISSUE
- exec_ready  in  1  execute accepts the issued instruction this cycle
- branch_taken  in  1  sampled with exec_ready: redirect PC
- branch_offset  in  16  signed byte offset, relative to issued instruction address
- skip_next  in  1  sampled with exec_ready: fetch then discard the next instruction
- pc  out  16  address of the instruction currently held in inst

Behaviour:
- Reset (rst_n low at a clk edge):
  - State FETCH_HI; fetch_pc = RESET_PC; pc = RESET_PC.
  - inst = 0, data = 0, dec_en = 0, mem_req = 0.
  - skip_pending = 0.
  - Reset mid-transaction abandons the request with no wait for ack; a late ack is ignored.
- States: FETCH_HI, FETCH_LO, FETCH_DATA, ISSUE (plus HALT, optional).
- FETCH_HI:
  - mem_req = 1, mem_addr = fetch_pc.
  - On ack: inst[15:8] = rdata; go to FETCH_LO.
- FETCH_LO:
  - mem_addr = fetch_pc + 1.
  - On ack: inst[7:0] = rdata.
  - If inst[15:14] == 2'b10 and inst[10:9] == 2'b01 (one-arg, data source): go to FETCH_DATA.
  - Otherwise: data = 0 and go to ISSUE.
- FETCH_DATA:
  - mem_addr = fetch_pc + 2.
  - On ack: data = rdata; go to ISSUE.
- mem_req deasserts for exactly one cycle between bytes (the state-entry cycle). mem_ack while mem_req = 0 is ignored.
- On entering ISSUE: pc = fetch_pc, and fetch_pc advances by the instruction length (2, or 3 with an operand).
- ISSUE, skip_pending = 1:
  - dec_en stays 0.
  - Clear skip_pending and return to FETCH_HI next cycle (instruction discarded).
- ISSUE, skip_pending = 0:
  - dec_en = 1; hold inst, data and pc stable until exec_ready.
  - On exec_ready with branch_taken: fetch_pc = pc + branch_offset (16-bit wrap); skip_next is ignored.
  - On exec_ready with skip_next (no branch): skip_pending = 1.
  - Either way, go to FETCH_HI.
- Issue rate and latency:
  - At most one issue per 3 cycles. With zero-wait memory: 2-byte instruction reaches ISSUE 4 cycles after FETCH_HI entry; 3-byte after 6.
  - exec_ready in the same cycle dec_en first rises is legal.
- All address arithmetic is modulo 2^16; e.g. fetch_pc 16'hFFFF reads the low byte from 16'h0000.

Optional Feature:
- Macro: FETCH_HALT_EN.
- Defined:
  - Adds input port halt (1 bit).
  - If halt is sampled high while in FETCH_HI before the request is issued, or in ISSUE after acceptance, go to HALT.
  - In HALT: mem_req = 0, dec_en = 0, all registers held.
  - Deasserting halt returns to FETCH_HI.
  - An in-flight byte transaction always completes before halting.
- Undefined: no halt port; no HALT state.

Decomposition:
- Shared package cpu_pkg holds:
  - The state enum.
  - Constants: ONE_ARG_MASK 16'hC000 / ONE_ARG_VAL 16'h8000; SRC_MASK 16'h0600 / SRC_DATA 16'h0200.
  - INST_LEN_BASE 2, INST_LEN_DATA 3.
- One sub-module, fetch_pc: holds the fetch_pc register and its next-value mux (reset, +len, branch target), keeping the adders out of the FSM.

Test Plan:
- Zero-wait memory, bytes 80 05 at 0x0000, exec_ready tied high -> inst = 16'h8005, data = 0, pc = 0, dec_en for 1 cycle; next fetch at 0x0002.
- Bytes 8A 00 2C -> three reads at 0/1/2; inst = 16'h8A00, data = 8'h2C; next fetch at 0x0003.
- Branch: issue at pc = 0x0010, exec_ready with branch_taken, offset 16'hFFF0 -> next mem_addr 0x0000.
- skip_next at pc = 0x0004 with a 3-byte instruction at 0x0006 -> reads 6/7/8 with dec_en never high; next issued pc = 0x0009.
- mem_ack delayed 5 cycles on the low byte -> mem_req and mem_addr = fetch_pc + 1 held stable; rst_n low mid-wait -> next cycle state FETCH_HI, outputs at reset values, mem_addr = RESET_PC.
- Wrap-around, plus (FETCH_HALT_EN) halt:
  - fetch_pc = 0xFFFF -> reads 0xFFFF, then 0x0000.
  - Halt asserted in FETCH_LO -> low byte completes, then mem_req stays 0 until halt drops.
